rom_streamer: RTL

//  Upstream address sequencer and downstream stream adapter for the iCE40 BRAM rom block.
//  - On a start command it reads a run of ROM words, starting at start_addr_i and length_i words long.
//  - It presents the words on a valid/ready stream that feeds the USB CDC IN data path.
//  - It stalls the ROM through rom_clke_o so that no skid buffer is needed.

---
 rtl/rom_streamer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rom_streamer.sv
// rom_streamer
//   Address sequencer for the iCE40 BRAM rom block that feeds a valid/ready
//   stream. It pulls a run of words from start_addr_i, length_i words long.
//   The ROM is stalled through rom_clke_o. Because of that, the registered
//   ROM output acts as the stream data register and no skid buffer is needed.
//
//   Configuration macro: ROM_STREAMER_WRAP_EN
//     defined   : addresses wrap from VECTOR_LENGTH-1 to 0 and the run length
//                 is taken as given. A start address past the end is reduced
//                 modulo VECTOR_LENGTH.
//     undefined : the run is truncated at the end of the ROM. A start address
//                 past the end gives an empty run.
//
// Ports
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   start_i            start request, sampled only while idle
//   start_addr_i       first word address, sampled with start_i
//   length_i           number of words, sampled with start_i
//   abort_i            synchronous abort of the current run
//   busy_o             high while a run is in progress
//   done_o             one-cycle pulse when a run completes or is aborted
//   rom_addr_o         ROM address
//   rom_clke_o         ROM clock enable; when low the ROM output holds
//   rom_data_i         ROM read data, with 1-cycle latency while clke=1
//   out_data_o         stream data, taken straight from rom_data_i
//   out_valid_o        stream valid
//   out_ready_i        stream ready
//   state_o            FSM state: 0 idle, 1 stream, 2 drain
//
// Handshake: a beat transfers on a rising edge where out_valid_o and
// out_ready_i are both high. Once out_valid_o rises, it and out_data_o hold
// until that transfer happens. The only exception is abort_i, which drops
// valid without a transfer.
module rom_streamer #(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_clke_o,
  input  logic [WORD_WIDTH-1:0] rom_data_i,
  output logic [WORD_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH+1)'(VECTOR_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LENGTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  out_valid_q;
  logic                  done_q;

  logic                  adv;
  logic                  issue;
  logic                  accept;
  logic [ADDR_WIDTH:0]   start_ext;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH:0]   eff_len;
  logic [ADDR_WIDTH-1:0] next_addr;

  // The ROM may only advance when the word it currently holds is free.
  // That is the case when nothing is presented, or when the word is being
  // taken this cycle.
  assign adv    = !out_valid_q || out_ready_i;
  assign accept = out_valid_q && out_ready_i;
  assign issue  = rom_clke_o;

  assign start_ext = {1'b0, start_addr_i};

`ifdef ROM_STREAMER_WRAP_EN
  // The start address is below 2*DEPTH, so one conditional subtract is a
  // full modulo.
  always_comb begin
    load_addr = start_addr_i;
    if (start_ext >= DEPTH) load_addr = ADDR_WIDTH'(start_ext - DEPTH);
    eff_len = length_i;
  end
`else
  logic [ADDR_WIDTH:0] avail;

  always_comb begin
    load_addr = start_addr_i;
    avail     = DEPTH - start_ext;
    eff_len   = '0;
    if (start_ext < DEPTH) eff_len = (length_i < avail) ? length_i : avail;
  end
`endif

  // Wrap explicitly so that a depth which is not a power of two still
  // stays inside the ROM. Without wrap the truncated length stops the run
  // before this matters.
  assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i && eff_len != '0) state_d = S_STREAM;
      S_STREAM: begin
        if (abort_i)                                  state_d = S_IDLE;
        else if (issue && remaining_q == 'd1)         state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_i || accept)                        state_d = S_IDLE;
      end
      default:                                        state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    rom_clke_o = adv && (state_q == S_STREAM);
  end

  // Datapath: address, word counter, stream valid, done pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (eff_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= load_addr;
              remaining_q <= eff_len;
            end
          end
        end
        S_STREAM: begin
          if (abort_i) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (issue) begin
            addr_q      <= next_addr;
            remaining_q <= remaining_q - 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (abort_i || accept) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign rom_addr_o  = addr_q;
  assign out_data_o  = rom_data_i;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule
